// File: rtl/s3g_packet_rx.sv
// s3g_packet_rx: S3G host-protocol byte receiver (0xD5 | len | payload | CRC-8 Maxim).
// Holds one accepted payload on a registered random-access read port until acknowledged.
`default_nettype none

module s3g_packet_rx #(
  parameter int MAX_PAYLOAD = 32,
  parameter int TIMEOUT     = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  input  logic       pkt_ack_i,
  input  logic [7:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic       pkt_valid_o,
  output logic [7:0] pkt_len_o,
  output logic       crc_err_o,
  output logic       len_err_o,
  output logic       timeout_o,
  output logic       overrun_o
);

  localparam int         AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int         CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int         TLIM_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TLIM = CW'(TLIM_I);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);
  localparam logic [7:0] SYNC    = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CRC     = 3'd3,
    S_HOLD    = 3'd4
  } state_e;

  state_e        state_q;
  logic [7:0]    len_q;
  logic [7:0]    idx_q;
  logic [7:0]    crc_q;
  logic [CW-1:0] tcnt_q;
  logic [7:0]    pkt_len_q;
  logic          pkt_valid_q;
  logic [7:0]    rd_data_q;
  logic          crc_err_q;
  logic          len_err_q;
  logic          timeout_q;
  logic          overrun_q;
  logic [7:0]    buf_q [0:MAX_PAYLOAD-1];

  logic [7:0]    crc_d;
  logic          w_active;
  logic          w_tmo;
  logic          w_rd_hit;

  // Reflected Dallas/Maxim CRC-8, one byte LSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  assign crc_d    = crc8_byte(crc_q, rx_data_i);
  assign w_active = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CRC);
  assign w_tmo    = (TIMEOUT != 0) && !rx_done_i && (tcnt_q == TLIM);
  assign w_rd_hit = (rd_addr_i < pkt_len_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      crc_q       <= '0;
      tcnt_q      <= '0;
      pkt_len_q   <= '0;
      pkt_valid_q <= 1'b0;
      rd_data_q   <= '0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      rd_data_q <= w_rd_hit ? buf_q[rd_addr_i[AW-1:0]] : 8'h00;

      if (!w_active || rx_done_i) begin
        tcnt_q <= '0;
      end else if (TIMEOUT != 0) begin
        tcnt_q <= tcnt_q + 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (rx_done_i && rx_data_i == SYNC) state_q <= S_LEN;
        end
        S_LEN: begin
          if (rx_done_i) begin
            len_q <= rx_data_i;
            crc_q <= '0;
            idx_q <= '0;
            if (rx_data_i > MAX_LEN) begin
              len_err_q <= 1'b1;
              state_q   <= S_IDLE;
            end else if (rx_data_i == 8'h00) begin
              state_q <= S_CRC;
            end else begin
              state_q <= S_PAYLOAD;
            end
          end else if (w_tmo) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (rx_done_i) begin
            crc_q <= crc_d;
            idx_q <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_q <= S_CRC;
          end else if (w_tmo) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_CRC: begin
          if (rx_done_i) begin
            if (rx_data_i == crc_q) begin
              pkt_len_q   <= len_q;
              pkt_valid_q <= 1'b1;
              state_q     <= S_HOLD;
            end else begin
              crc_err_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end else if (w_tmo) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_HOLD: begin
          // An ack releases the packet and lets a coincident byte start a new hunt.
          if (pkt_ack_i) begin
            pkt_valid_q <= 1'b0;
            state_q     <= (rx_done_i && rx_data_i == SYNC) ? S_LEN : S_IDLE;
          end else if (rx_done_i) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_PAYLOAD && rx_done_i) buf_q[idx_q[AW-1:0]] <= rx_data_i;
  end

  assign rd_data_o   = rd_data_q;
  assign pkt_valid_o = pkt_valid_q;
  assign pkt_len_o   = pkt_len_q;
  assign crc_err_o   = crc_err_q;
  assign len_err_o   = len_err_q;
  assign timeout_o   = timeout_q;
  assign overrun_o   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_s3g_packet_rx.sv
// tb_s3g_packet_rx: directed spec scenarios plus randomized packet traffic,
// checked every cycle against a packet-level reference model.
`default_nettype none

module tb_s3g_packet_rx;
  localparam int MAXP = 32;
  localparam int TMO  = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       pkt_ack = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic       pkt_valid;
  logic [7:0] pkt_len;
  logic       crc_err, len_err, timeout, overrun;

  always #5 clk = ~clk;

  s3g_packet_rx #(.MAX_PAYLOAD(MAXP), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_done_i(rx_done),
    .pkt_ack_i(pkt_ack), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .pkt_valid_o(pkt_valid), .pkt_len_o(pkt_len), .crc_err_o(crc_err),
    .len_err_o(len_err), .timeout_o(timeout), .overrun_o(overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit rand_rd = 1'b0;
  int n_crc = 0, n_len = 0, n_tmo = 0, n_ovr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 8'h8C;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  // Reference model: 0 hunt, 1 want length, 2 collecting, 3 want crc, 4 holding
  int         m_mode = 0;
  int         m_want = 0;
  int         m_gap  = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_mem [MAXP];
  logic       e_valid = 0, e_crc = 0, e_lenerr = 0, e_tmo = 0, e_ovr = 0;
  logic [7:0] e_len = 0, e_rd = 0;

  function automatic logic [7:0] crc_of_queue();
    logic [7:0] c;
    c = 8'h00;
    foreach (m_q[i]) c = crc_upd(c, m_q[i]);
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_gap = 0; m_q.delete();
      e_valid = 0; e_len = 0; e_rd = 0;
      e_crc = 0; e_lenerr = 0; e_tmo = 0; e_ovr = 0;
    end else begin
      e_rd = (rd_addr < e_len) ? m_mem[rd_addr] : 8'h00;
      e_crc = 0; e_lenerr = 0; e_tmo = 0; e_ovr = 0;
      if (m_mode == 4) begin
        if (pkt_ack) begin
          e_valid = 0;
          m_mode  = 0;
        end else if (rx_done) begin
          e_ovr = 1;
        end
      end
      if (m_mode >= 1 && m_mode <= 3 && !rx_done) begin
        m_gap++;
        if (m_gap >= TMO) begin
          e_tmo  = 1;
          m_mode = 0;
        end
      end
      if (rx_done) begin
        m_gap = 0;
        case (m_mode)
          0: if (rx_data == 8'hD5) m_mode = 1;
          1: begin
            m_want = int'(rx_data);
            m_q.delete();
            if (m_want > MAXP) begin e_lenerr = 1; m_mode = 0; end
            else m_mode = (m_want == 0) ? 3 : 2;
          end
          2: begin
            m_mem[m_q.size()] = rx_data;
            m_q.push_back(rx_data);
            if (m_q.size() == m_want) m_mode = 3;
          end
          3: begin
            if (rx_data == crc_of_queue()) begin
              e_valid = 1; e_len = 8'(m_want); m_mode = 4;
            end else begin
              e_crc = 1; m_mode = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pkt_valid", {31'd0, pkt_valid}, {31'd0, e_valid});
      chk("pkt_len",   {24'd0, pkt_len},   {24'd0, e_len});
      chk("rd_data",   {24'd0, rd_data},   {24'd0, e_rd});
      chk("crc_err",   {31'd0, crc_err},   {31'd0, e_crc});
      chk("len_err",   {31'd0, len_err},   {31'd0, e_lenerr});
      chk("timeout",   {31'd0, timeout},   {31'd0, e_tmo});
      chk("overrun",   {31'd0, overrun},   {31'd0, e_ovr});
    end
    if (crc_err) n_crc++;
    if (len_err) n_len++;
    if (timeout) n_tmo++;
    if (overrun) n_ovr++;
  end

  always @(posedge clk) begin
    if (rand_rd) begin
      #1;
      rd_addr = 8'($urandom_range(0, 40));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic ack(input bit with_byte, input logic [7:0] b);
    pkt_ack = 1'b1; rx_done = with_byte; rx_data = b;
    @(posedge clk); #1;
    pkt_ack = 1'b0; rx_done = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int gap);
    foreach (s[i]) begin strobe(s[i]); idle(gap); end
  endtask

  task automatic read_chk(input string nm, input logic [7:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    @(posedge clk); #1;
    chk(nm, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic rand_gap();
    int r;
    r = $urandom_range(0, 39);
    if      (r == 0) idle(TMO - 1);
    else if (r == 1) idle(TMO);
    else if (r == 2) idle(TMO + 4);
    else if (r < 6)  idle($urandom_range(3, 10));
    else             idle($urandom_range(0, 2));
  endtask

  task automatic rand_packet();
    int len, r;
    logic [7:0] c, b;
    repeat ($urandom_range(0, 2)) begin strobe(8'($urandom)); rand_gap(); end
    strobe(8'hD5); rand_gap();
    r = $urandom_range(0, 19);
    len = (r < 2) ? $urandom_range(MAXP + 1, 255) : (r < 5) ? $urandom_range(0, MAXP) : $urandom_range(0, 8);
    strobe(8'(len)); rand_gap();
    if (len <= MAXP) begin
      c = 8'h00;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        c = crc_upd(c, b);
        strobe(b); rand_gap();
      end
      if ($urandom_range(0, 4) == 0) c = c ^ (8'h01 << $urandom_range(0, 7));
      strobe(c); idle($urandom_range(0, 3));
    end
    r = $urandom_range(0, 3);
    if (r == 0) begin strobe(8'($urandom)); idle(1); end
    else if (r == 1) ack(1'b1, ($urandom_range(0, 1) == 1) ? 8'hD5 : 8'($urandom));
    else if (r == 2) ack(1'b0, 8'h00);
    if ($urandom_range(0, 1) == 1) ack(1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] seq[$];
    logic [7:0] pay[3];
    int base;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;

    idle(3);
    chk_en = 1'b1;
    chk("reset pkt_valid", {31'd0, pkt_valid}, 32'd0);
    chk("reset pkt_len", {24'd0, pkt_len}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Noise then a valid packet, strobes 10 cycles apart
    strobe(8'h0D); idle(9);
    seq = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    send_seq(seq, 9);
    chk("pkt1 valid", {31'd0, pkt_valid}, 32'd1);
    chk("pkt1 len", {24'd0, pkt_len}, 32'd3);
    for (int i = 0; i < 3; i++) read_chk("pkt1 rd", 8'(i), pay[i]);
    read_chk("pkt1 rd beyond len", 8'd3, 8'h00);

    base = n_ovr;
    strobe(8'h55); idle(1);
    chk("overrun pulses", n_ovr - base, 32'd1);
    for (int i = 0; i < 3; i++) read_chk("frozen rd", 8'(i), pay[i]);
    ack(1'b0, 8'h00);
    chk("ack clears valid", {31'd0, pkt_valid}, 32'd0);

    base = n_crc;
    seq = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hCC};
    send_seq(seq, 2);
    chk("crc_err pulses", n_crc - base, 32'd1);
    chk("bad crc no valid", {31'd0, pkt_valid}, 32'd0);

    base = n_len;
    seq = '{8'hD5, 8'h21};
    send_seq(seq, 2);
    chk("len_err pulses", n_len - base, 32'd1);
    seq = '{8'hD5, 8'h00, 8'h00};
    send_seq(seq, 2);
    chk("empty pkt valid", {31'd0, pkt_valid}, 32'd1);
    chk("empty pkt len", {24'd0, pkt_len}, 32'd0);
    ack(1'b0, 8'h00);

    base = n_tmo;
    seq = '{8'hD5, 8'h03, 8'h01};
    send_seq(seq, 1);
    idle(TMO + 10);
    chk("timeout pulses", n_tmo - base, 32'd1);
    seq = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    send_seq(seq, 1);
    chk("after timeout valid", {31'd0, pkt_valid}, 32'd1);
    ack(1'b0, 8'h00);

    seq = '{8'hD5, 8'h03, 8'h01, 8'h02};
    send_seq(seq, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst pkt_len", {24'd0, pkt_len}, 32'd0);
    chk("async rst rd_data", {24'd0, rd_data}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    seq = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    send_seq(seq, 0);
    chk("post-reset valid", {31'd0, pkt_valid}, 32'd1);
    read_chk("post-reset rd", 8'd2, 8'h03);
    ack(1'b0, 8'h00);

    rand_rd = 1'b1;
    repeat (300) rand_packet();
    rand_rd = 1'b0;
    ack(1'b0, 8'h00);
    idle(3);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
